// File: rtl/aes_stream_pkg.sv
// Shared constants and state encoding for the AES byte-stream receiver.
package aes_stream_pkg;

    localparam int BLOCK_BYTES     = 16;
    localparam int BLOCK_W         = 128;
    localparam int CNT_W           = 4;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } rx_state_e;

endpackage

// File: rtl/aes_stream_rx_if.sv
// Byte-stream input and block-output handshake bundle of aes_stream_rx.
interface aes_stream_rx_if;
    import aes_stream_pkg::*;

    logic               rx_cu;
    logic               rx_id;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic [BLOCK_W-1:0] blk_data;
    logic               blk_cu;
    logic               blk_id;
    logic               blk_valid;
    logic               blk_ready;

    // master: byte producer plus block consumer; slave: the receiver
    modport master (
        output rx_cu, rx_id, rx_data, rx_valid, blk_ready,
        input  blk_data, blk_cu, blk_id, blk_valid
    );

    modport slave (
        input  rx_cu, rx_id, rx_data, rx_valid, blk_ready,
        output blk_data, blk_cu, blk_id, blk_valid
    );

endinterface

// File: rtl/aes_toggle_sync.sv
// Two-flop synchronizer plus history flop turning a toggle strobe into a one-cycle event.
module aes_toggle_sync (
    input  logic clk,
    input  logic rst,
    input  logic tog_in,
    output logic event_out
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= tog_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign event_out = sync2_q ^ hist_q;

endmodule

// File: rtl/aes_stream_rx.sv
// Assembles 16 toggle-strobed bytes into a 128-bit block with tag, handshake and sticky errors.
// state   | meaning
// ST_IDLE | no partial block; next byte is byte 0 and sets the tag
// ST_FILL | bytes 1..15 being shifted in; idle timer running
module aes_stream_rx
    import aes_stream_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_cu,
    input  logic               rx_id,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [BLOCK_W-1:0] blk_data,
    output logic               blk_cu,
    output logic               blk_id,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic               err_overrun,
    output logic               err_tag,
    output logic               err_timeout
);

    localparam int SHIFT_W = BLOCK_W - 8;
    localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT_CYC - 1);

    logic byte_ev;

    rx_state_e          state_q,       state_d;
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic [SHIFT_W-1:0] shift_q,       shift_d;
    logic               tag_cu_q,      tag_cu_d;
    logic               tag_id_q,      tag_id_d;
    logic [BLOCK_W-1:0] blk_data_q,    blk_data_d;
    logic               blk_cu_q,      blk_cu_d;
    logic               blk_id_q,      blk_id_d;
    logic               blk_valid_q,   blk_valid_d;
    logic [TMO_W-1:0]   tmo_q,         tmo_d;
    logic               err_overrun_q, err_overrun_d;
    logic               err_tag_q,     err_tag_d;
    logic               err_timeout_q, err_timeout_d;

    aes_toggle_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .tog_in    (rx_valid),
        .event_out (byte_ev)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            tag_cu_q      <= 1'b0;
            tag_id_q      <= 1'b0;
            blk_data_q    <= '0;
            blk_cu_q      <= 1'b0;
            blk_id_q      <= 1'b0;
            blk_valid_q   <= 1'b0;
            tmo_q         <= '0;
            err_overrun_q <= 1'b0;
            err_tag_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            tag_cu_q      <= tag_cu_d;
            tag_id_q      <= tag_id_d;
            blk_data_q    <= blk_data_d;
            blk_cu_q      <= blk_cu_d;
            blk_id_q      <= blk_id_d;
            blk_valid_q   <= blk_valid_d;
            tmo_q         <= tmo_d;
            err_overrun_q <= err_overrun_d;
            err_tag_q     <= err_tag_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        tag_cu_d      = tag_cu_q;
        tag_id_d      = tag_id_q;
        blk_data_d    = blk_data_q;
        blk_cu_d      = blk_cu_q;
        blk_id_d      = blk_id_q;
        blk_valid_d   = blk_valid_q;
        tmo_d         = tmo_q;
        err_overrun_d = err_overrun_q;
        err_tag_d     = err_tag_q;
        err_timeout_d = err_timeout_q;

        if (blk_valid_q && blk_ready) begin
            blk_valid_d = 1'b0;
        end

        if (byte_ev) begin
            tmo_d = TMO_RELOAD;
            cnt_d = cnt_q + CNT_W'(1);
            if (state_q == ST_IDLE) begin
                shift_d  = {{(SHIFT_W-8){1'b0}}, rx_data};
                tag_cu_d = rx_cu;
                tag_id_d = rx_id;
                state_d  = ST_FILL;
            end else begin
                if ((rx_cu != tag_cu_q) || (rx_id != tag_id_q)) begin
                    err_tag_d = 1'b1;
                end
                shift_d = {shift_q[SHIFT_W-9:0], rx_data};
                if (cnt_q == CNT_W'(BLOCK_BYTES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    // A same-edge handshake frees the holding register for the new block
                    if (!blk_valid_q || blk_ready) begin
                        blk_data_d  = {shift_q, rx_data};
                        blk_cu_d    = tag_cu_q;
                        blk_id_d    = tag_id_q;
                        blk_valid_d = 1'b1;
                    end else begin
                        err_overrun_d = 1'b1;
                    end
                end
            end
        end else if (state_q == ST_FILL) begin
            if (tmo_q == '0) begin
                state_d       = ST_IDLE;
                cnt_d         = '0;
                err_timeout_d = 1'b1;
            end else begin
                tmo_d = tmo_q - TMO_W'(1);
            end
        end
    end

    assign blk_data    = blk_data_q;
    assign blk_cu      = blk_cu_q;
    assign blk_id      = blk_id_q;
    assign blk_valid   = blk_valid_q;
    assign err_overrun = err_overrun_q;
    assign err_tag     = err_tag_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_aes_stream_rx.sv
// Randomized scenario bench for aes_stream_rx against a queue-based block model.
module tb_aes_stream_rx;
    import aes_stream_pkg::*;

    localparam int TMO = 64;

    typedef struct {
        logic [BLOCK_W-1:0] data;
        logic               cu;
        logic               id;
    } blk_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err_overrun, err_tag, err_timeout;

    aes_stream_rx_if bus ();

    aes_stream_rx #(.TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_cu       (bus.rx_cu),
        .rx_id       (bus.rx_id),
        .rx_data     (bus.rx_data),
        .rx_valid    (bus.rx_valid),
        .blk_data    (bus.blk_data),
        .blk_cu      (bus.blk_cu),
        .blk_id      (bus.blk_id),
        .blk_valid   (bus.blk_valid),
        .blk_ready   (bus.blk_ready),
        .err_overrun (err_overrun),
        .err_tag     (err_tag),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    blk_t       exp_q[$];
    blk_t       got_q[$];
    logic [7:0] part_q[$];
    logic       part_cu, part_id;
    logic       m_tag_err;

    // consumer monitor: a block is taken on the next edge when valid and ready
    always begin
        @(negedge clk);
        #1;
        if (rst && bus.blk_valid && bus.blk_ready) begin
            got_q.push_back('{bus.blk_data, bus.blk_cu, bus.blk_id});
        end
    end

    task automatic model_byte(input logic [7:0] d, input logic cu, input logic id);
        blk_t b;
        if (part_q.size() == 0) begin
            part_cu = cu;
            part_id = id;
        end else if (cu != part_cu || id != part_id) begin
            m_tag_err = 1'b1;
        end
        part_q.push_back(d);
        if (part_q.size() == BLOCK_BYTES) begin
            b.data = '0;
            for (int i = 0; i < BLOCK_BYTES; i++) b.data = {b.data[BLOCK_W-9:0], part_q[i]};
            b.cu = part_cu;
            b.id = part_id;
            exp_q.push_back(b);
            part_q.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic cu, input logic id, input int gap);
        @(negedge clk);
        bus.rx_data  = d;
        bus.rx_cu    = cu;
        bus.rx_id    = id;
        bus.rx_valid = ~bus.rx_valid;
        model_byte(d, cu, id);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete();
        got_q.delete();
        part_q.delete();
        m_tag_err = 1'b0;
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0; bus.rx_data = '0; bus.rx_cu = 1'b0; bus.rx_id = 1'b0;
        bus.blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.blk_data !== '0) begin bad++; $display("FAIL reset_blk_data got=%h want=0", bus.blk_data); end
        total++; if ({bus.blk_cu, bus.blk_id, bus.blk_valid} !== 3'b000) begin bad++; $display("FAIL reset_blk_flags got=%b want=000", {bus.blk_cu, bus.blk_id, bus.blk_valid}); end
        total++; if ({err_overrun, err_tag, err_timeout} !== 3'b000) begin bad++; $display("FAIL reset_errs got=%b want=000", {err_overrun, err_tag, err_timeout}); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.blk_valid !== 1'b0) begin bad++; $display("FAIL reset_release_valid got=%b want=0", bus.blk_valid); end
        m_tag_err = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        bus.blk_ready = 1'b1;
        for (int i = 0; i < 48; i++) send_byte((i / 16 == 1) ? 8'h01 : 8'h00, 1'b0, 1'b0, 16);
        repeat (8) @(negedge clk);
        total++; if (got_q.size() !== 3) begin bad++; $display("FAIL stream_count got=%0d want=3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            total++; if (got_q[i].data !== exp_q[i].data) begin bad++; $display("FAIL stream_blk%0d got=%h want=%h", i, got_q[i].data, exp_q[i].data); end
        end
        total++; if ({err_overrun, err_tag, err_timeout} !== 3'b000) begin bad++; $display("FAIL stream_errs got=%b want=000", {err_overrun, err_tag, err_timeout}); end
    endtask

    task automatic test_random();
        logic cu, id;
        do_reset();
        bus.blk_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            cu = 1'($urandom); id = 1'($urandom);
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                if (i == 5 && $urandom_range(0, 3) == 0) send_byte(8'($urandom), cu, ~id, $urandom_range(4, 20));
                else send_byte(8'($urandom), cu, id, $urandom_range(4, 20));
            end
        end
        repeat (8) @(negedge clk);
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_blk%0d got=%h/%b%b want=%h/%b%b", i, got_q[i].data, got_q[i].cu, got_q[i].id, exp_q[i].data, exp_q[i].cu, exp_q[i].id); end
        end
        total++; if (err_tag !== m_tag_err) begin bad++; $display("FAIL rand_err_tag got=%b want=%b", err_tag, m_tag_err); end
        total++; if ({err_overrun, err_timeout} !== 2'b00) begin bad++; $display("FAIL rand_errs got=%b want=00", {err_overrun, err_timeout}); end
    endtask

    task automatic test_overrun();
        do_reset();
        for (int i = 0; i < 32; i++) send_byte(8'($urandom), 1'b1, 1'b0, 12);
        repeat (4) @(negedge clk);
        total++; if (bus.blk_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", bus.blk_valid); end
        total++; if (bus.blk_data !== exp_q[0].data) begin bad++; $display("FAIL ovr_held got=%h want=%h", bus.blk_data, exp_q[0].data); end
        total++; if (err_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", err_overrun); end
        bus.blk_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++; if (bus.blk_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain_valid got=%b want=0", bus.blk_valid); end
        total++; if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin bad++; $display("FAIL ovr_accepted n=%0d want first block %h", got_q.size(), exp_q[0].data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0, 1'b1, 8);
        for (int i = 0; i < 15; i++) send_byte(8'($urandom), 1'b0, 1'b1, 8);
        d = 8'($urandom);
        @(negedge clk);
        bus.rx_data = d; bus.rx_valid = ~bus.rx_valid;
        model_byte(d, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        total++; if (bus.blk_valid !== 1'b1 || bus.blk_data !== exp_q[0].data) begin bad++; $display("FAIL b2b_before got=%b/%h want=1/%h", bus.blk_valid, bus.blk_data, exp_q[0].data); end
        bus.blk_ready = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.blk_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", bus.blk_valid); end
        total++; if (bus.blk_data !== exp_q[1].data) begin bad++; $display("FAIL b2b_data got=%h want=%h", bus.blk_data, exp_q[1].data); end
        total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b want=0", err_overrun); end
        repeat (4) @(negedge clk);
        total++; if (got_q.size() !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_blk%0d got=%h want=%h", i, got_q[i].data, exp_q[i].data); end
        end
    endtask

    task automatic test_tag();
        do_reset();
        bus.blk_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0, (i < 8) ? 1'b1 : 1'b0, 6);
        repeat (6) @(negedge clk);
        total++; if (got_q.size() !== 1 || got_q[0].id !== 1'b1 || got_q[0].data !== exp_q[0].data) begin bad++; $display("FAIL tag_block n=%0d want id=1 data=%h", got_q.size(), exp_q[0].data); end
        total++; if (err_tag !== 1'b1) begin bad++; $display("FAIL tag_err got=%b want=1", err_tag); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.blk_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, 1'b0, 8);
        repeat (TMO + 20) @(negedge clk);
        part_q.delete();
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL tmo_flag got=%b want=1", err_timeout); end
        total++; if (got_q.size() !== 0 || bus.blk_valid !== 1'b0) begin bad++; $display("FAIL tmo_no_block n=%0d valid=%b want 0/0", got_q.size(), bus.blk_valid); end
        for (int i = 0; i < 16; i++) send_byte(8'hA5, 1'b0, 1'b0, 8);
        repeat (6) @(negedge clk);
        total++; if (got_q.size() !== 1 || got_q[0].data !== {16{8'hA5}}) begin bad++; $display("FAIL tmo_next_block n=%0d want %h", got_q.size(), {16{8'hA5}}); end
        repeat (TMO + 20) @(negedge clk);
        total++; if (err_overrun !== 1'b0 || err_tag !== 1'b0) begin bad++; $display("FAIL tmo_other_errs got=%b%b want=00", err_overrun, err_tag); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1, 1'b1, 6);
        for (int i = 0; i < 9; i++) send_byte(8'($urandom), 1'b1, i[0], 6);
        total++; if (bus.blk_valid !== 1'b1 || err_tag !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%b%b want=11", bus.blk_valid, err_tag); end
        @(negedge clk);
        rst = 1'b0;
        bus.rx_valid = 1'b0;
        #1;
        total++; if (bus.blk_data !== '0 || {bus.blk_cu, bus.blk_id, bus.blk_valid} !== 3'b000) begin bad++; $display("FAIL rmid_outs got=%h/%b want=0/000", bus.blk_data, {bus.blk_cu, bus.blk_id, bus.blk_valid}); end
        total++; if ({err_overrun, err_tag, err_timeout} !== 3'b000) begin bad++; $display("FAIL rmid_errs got=%b want=000", {err_overrun, err_tag, err_timeout}); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete(); got_q.delete(); part_q.delete(); m_tag_err = 1'b0;
        bus.blk_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0, 6);
        repeat (6) @(negedge clk);
        total++; if (got_q.size() !== 1 || got_q[0].data !== 128'h000102030405060708090A0B0C0D0E0F) begin bad++; $display("FAIL rmid_block n=%0d want 000102030405060708090a0b0c0d0e0f", got_q.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_random();
        test_overrun();
        test_back_to_back();
        test_tag();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
